// File: rtl/jk_excitation_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_excitation_driver
// Purpose  : Converts a stream of requested q values for a downstream JK
//            flip-flop into registered j/k excitation pairs, one per clock.
//            Targets arrive over valid/ready and are buffered in a FIFO.
//            An optional readback checker compares q_fb against the value
//            each popped target should have produced.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH        FIFO entries (power of 2, >= 2)
//   TOGGLE_PREF  don't-care fill for unused j/k: 0 -> drive 0, 1 -> drive 1
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   tgt_valid  in   target bit offered
//   tgt_bit    in   requested next q value
//   tgt_ready  out  FIFO can accept a bit (= !full)
//   en         in   1 = drain FIFO, 0 = hold (pushes still accepted)
//   j, k       out  registered excitation to the JK flip-flop
//   q_fb       in   q read back from the JK flip-flop
//   err        out  one-cycle pulse on readback mismatch
//   err_cnt    out  saturating mismatch count
// Configuration
//   JKDRV_CHECK_EN  defined: readback checker built; undefined: err and
//                   err_cnt tied to 0 and q_fb ignored.
// ============================================================================
module jk_excitation_driver #(
  parameter int DEPTH       = 8,
  parameter bit TOGGLE_PREF = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tgt_valid,
  input  logic       tgt_bit,
  output logic       tgt_ready,
  input  logic       en,
  output logic       j,
  output logic       k,
  input  logic       q_fb,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          mem [DEPTH];
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          head;
  logic          q_exp;
  logic          j_nxt;
  logic          k_nxt;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tgt_ready = ~full;
  assign push      = tgt_valid & ~full;
  assign pop       = en & ~empty;
  assign head      = mem[rd_ptr[AW-1:0]];

  // Excitation: the driven input is the one that forces the transition;
  // the other is a don't-care filled with TOGGLE_PREF.
  //   from 0: j = target,      k = don't-care
  //   from 1: j = don't-care,  k = ~target
  always_comb begin
    j_nxt = q_exp ? TOGGLE_PREF : head;
    k_nxt = q_exp ? ~head       : TOGGLE_PREF;
  end

  // FIFO write side; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= tgt_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Control FSM: pops and registers one excitation pair per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rd_ptr <= '0;
      j      <= 1'b0;
      k      <= 1'b0;
      q_exp  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!pop) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (pop) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        j      <= j_nxt;
        k      <= k_nxt;
        q_exp  <= head;
      end else begin
        j      <= 1'b0;
        k      <= 1'b0;
      end
    end
  end

`ifdef JKDRV_CHECK_EN
  // Two-stage {valid, expected} shift: a bit popped at edge N drives j/k
  // after N, the flip-flop samples at N+1, and q_fb is compared at N+2.
  logic s1_v;
  logic s1_e;
  logic s2_v;
  logic s2_e;
  logic mismatch;

  assign mismatch = s2_v & (q_fb != s2_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_e    <= 1'b0;
      s2_v    <= 1'b0;
      s2_e    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      s1_v <= pop;
      s1_e <= pop ? head : 1'b0;
      s2_v <= s1_v;
      s2_e <= s1_e;
      err  <= mismatch;
      if (mismatch && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
  assign err_cnt     = 8'd0;
`endif

endmodule
`default_nettype wire
